// File: rtl/imem_loader.sv
// imem_loader: fills the instruction memory from a byte stream and holds the
// CPU until the image is in place.
//
// Stream format: a 16-bit big-endian word count, then count*4 bytes. Each
// group of four bytes becomes one big-endian 32-bit word. The words are
// written to consecutive byte addresses from BASE_ADDR, stepping by 4.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous reset, active low
//   start      one-cycle pulse; begins a load from IDLE, DONE or ERR
//   in_data    stream byte
//   in_valid   in_data is valid
//   in_ready   loader accepts a byte this cycle
//   mem_we     instruction-memory write enable, one pulse per word
//   mem_addr   byte address of the write (holds between writes)
//   mem_wdata  word to write (holds between writes)
//   cpu_hold   keeps the fetch PC in reset while high
//   done       image loaded; held until the next start or reset
//   error      length header exceeded MAX_WORDS; held until start or reset
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | after reset, waiting for start; CPU held
// S_LEN_HI | waiting for the high byte of the word count
// S_LEN_LO | waiting for the low byte; count is checked on arrival
// S_DATA   | shifting in the four bytes of the current word
// S_WRITE  | one-cycle memory write of the assembled word
// S_DONE   | image loaded; CPU released
// S_ERR    | count too large; CPU held, nothing written

module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  // One extra bit so a MAX_WORDS of 65536 still compares correctly.
  localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

  state_t      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] word_idx_q, word_idx_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] shift_q, shift_d;
  logic        in_ready_q, in_ready_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        cpu_hold_q, cpu_hold_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

  logic        xfer;
  logic [15:0] len_new;

  // in_ready_q always mirrors the decode of state_q, so this is the handshake.
  assign xfer = in_valid & in_ready_q;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    word_idx_d  = word_idx_q;
    byte_cnt_d  = byte_cnt_q;
    shift_d     = shift_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    len_new     = {len_q[15:8], in_data};

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_LEN_HI;
          word_idx_d = '0;
          byte_cnt_d = '0;
        end
      end
      S_LEN_HI: begin
        if (xfer) begin
          len_d   = {in_data, len_q[7:0]};
          state_d = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          len_d = len_new;
          if (len_new == 16'd0) begin
            state_d = S_DONE;
          end else if ({1'b0, len_new} > MAX_LEN) begin
            state_d = S_ERR;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          shift_d    = {shift_q[23:0], in_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        if (word_idx_q == len_q - 16'd1) begin
          state_d = S_DONE;
        end else begin
          word_idx_d = word_idx_q + 16'd1;
          state_d    = S_DATA;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered: decoded from the next state so they line up
    // with the state they belong to.
    in_ready_d = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) ||
                 (state_d == S_DATA);
    mem_we_d   = (state_d == S_WRITE);
    if (state_d == S_WRITE) begin
      // word_idx only advances on leaving WRITE, so this is the current word.
      mem_addr_d  = BASE_ADDR + {14'd0, word_idx_d, 2'b00};
      mem_wdata_d = shift_d;
    end
    cpu_hold_d = (state_d != S_DONE);
    done_d     = (state_d == S_DONE);
    error_d    = (state_d == S_ERR);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      word_idx_q  <= '0;
      byte_cnt_q  <= '0;
      shift_q     <= '0;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= BASE_ADDR;
      mem_wdata_q <= '0;
      cpu_hold_q  <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      word_idx_q  <= word_idx_d;
      byte_cnt_q  <= byte_cnt_d;
      shift_q     <= shift_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_hold_q  <= cpu_hold_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_hold  = cpu_hold_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: a reference model turns each byte image into the
// list of expected (address, word) writes; a monitor pops and compares them
// whenever mem_we is seen.
module tb_imem_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          MAXW = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready, mem_we, cpu_hold, done, error;
  logic [31:0] mem_addr, mem_wdata;

  imem_loader dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_hold(cpu_hold),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t sb[$];
  int  wr_cyc[$];
  int  cyc = 0;
  int  tests = 0;
  int  fails = 0;
  bit  chk_ready = 1'b0;
  wr_t exp_wr;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst && mem_we) begin
      wr_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write", mem_addr, mem_wdata);
      end else begin
        exp_wr = sb.pop_front();
        chk("wr_addr", mem_addr, exp_wr.addr);
        chk("wr_data", mem_wdata, exp_wr.data);
      end
    end
    // While loading, in_ready may only drop during a write cycle.
    if (chk_ready) chk("ready_only_low_in_write", 32'(in_ready), 32'(!mem_we && !done));
  end

  // Reference model: returns 0 for a good image, 1 for an oversize header,
  // and pushes the expected writes.
  task automatic model(input logic [7:0] img[$], output int outcome, output int len);
    wr_t w;
    len = img[0] * 256 + img[1];
    if (len > MAXW) begin
      outcome = 1;
    end else begin
      outcome = 0;
      for (int i = 0; i < len; i++) begin
        w.addr = BASE + 32'(4 * i);
        w.data = (32'(img[2+4*i]) << 24) + (32'(img[3+4*i]) << 16) +
                 (32'(img[4+4*i]) << 8) + 32'(img[5+4*i]);
        sb.push_back(w);
      end
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    repeat (gap) @(negedge clk);
  endtask

  // gap < 0 selects a random 0..2 cycle gap after each byte.
  task automatic run_image(input logic [7:0] img[$], input int gap, input bit spacing,
                           input int mid_start, input bit pre_valid);
    int outcome, len, n0, n, g;
    model(img, outcome, len);
    n0 = wr_cyc.size();
    if (pre_valid) begin
      in_valid = 1'b1;
      in_data  = img[0];
    end
    pulse_start();
    chk("start_clears_done", 32'(done), 32'd0);
    chk("start_clears_error", 32'(error), 32'd0);
    chk("start_sets_hold", 32'(cpu_hold), 32'd1);
    for (int i = 0; i < img.size(); i++) begin
      if (i == mid_start) pulse_start();
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      if (i == img.size() - 1) g = 0;
      send_byte(img[i], g);
    end
    n = 0;
    while (!done && !error && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("flag_latency", 32'(n), (outcome == 0 && len > 0) ? 32'd1 : 32'd0);
    chk("done", 32'(done), 32'(outcome == 0));
    chk("error", 32'(error), 32'(outcome == 1));
    chk("cpu_hold", 32'(cpu_hold), 32'(outcome == 1));
    chk("all_writes_seen", 32'(sb.size()), 32'd0);
    if (spacing && outcome == 0 && len >= 2)
      chk("write_spacing", 32'(wr_cyc[n0+1] - wr_cyc[n0]), 32'd5);
    sb.delete();
  endtask

  logic [7:0] img[$];
  logic [7:0] rimg[$];
  int         rlen;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, BASE);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    img = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    run_image(img, 0, 1'b1, -1, 1'b0);

    chk_ready = 1'b1;
    run_image(img, 3, 1'b0, -1, 1'b0);
    chk_ready = 1'b0;

    run_image('{8'h00, 8'h00}, 0, 1'b0, -1, 1'b0);

    run_image('{8'h01, 8'h01}, 0, 1'b0, -1, 1'b0);
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("err_no_ready", 32'(in_ready), 32'd0);
    chk("err_held", 32'(error), 32'd1);
    in_valid = 1'b0;
    run_image('{8'h00, 8'h01, 8'hCA, 8'hFE, 8'hBA, 8'hBE}, 0, 1'b0, -1, 1'b0);

    // Reset in the middle of word 1.
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    #2 rst = 1'b0;
    #1;
    chk("midrst_hold", 32'(cpu_hold), 32'd1);
    chk("midrst_ready", 32'(in_ready), 32'd0);
    chk("midrst_we", 32'(mem_we), 32'd0);
    chk("midrst_addr", mem_addr, BASE);
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("after_rst_hold", 32'(cpu_hold), 32'd1);
    chk("after_rst_done", 32'(done), 32'd0);
    run_image('{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04}, 0, 1'b0, -1, 1'b0);

    // start while in DATA is ignored; then start from DONE with in_valid high.
    run_image(img, 1, 1'b0, 4, 1'b0);
    run_image('{8'h00, 8'h01, 8'hA5, 8'h5A, 8'h0F, 8'hF0}, 0, 1'b0, -1, 1'b1);

    // Largest accepted image.
    rimg = '{8'h01, 8'h00};
    for (int i = 0; i < 4 * MAXW; i++) rimg.push_back(8'($urandom));
    run_image(rimg, 0, 1'b1, -1, 1'b0);

    for (int k = 0; k < 8; k++) begin
      rlen = int'($urandom_range(1, 6));
      rimg = '{8'h00, 8'(rlen)};
      for (int i = 0; i < 4 * rlen; i++) rimg.push_back(8'($urandom));
      run_image(rimg, -1, 1'b0, -1, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
